uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (mid-bit sampling, glitch reject, framing check) feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the o_parity_err output.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_rx_in,
    input  logic                               i_rd_ready,
    output logic                               o_rd_valid,
    output logic [7:0]                         o_rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
    output logic                               o_busy,
    output logic                               o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                               o_parity_err,
`endif
    output logic                               o_overrun
);

    localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0]   HalfM1   = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0]   FullM1   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CountW-1:0] DepthCnt = CountW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    state_t          r_state, w_state_d;
    logic [CntW-1:0] r_bit_cnt, w_bit_cnt_d;
    logic [2:0]      r_bit_idx, w_bit_idx_d;
    logic [7:0]      r_shreg, w_shreg_d;
    logic            w_bit_end;
    logic            w_push_req;
    logic            w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bit, w_par_bit_d;
    logic            w_parity_err;
`endif

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CountW-1:0] r_count;
    logic              w_full, w_pop, w_push;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_in};
        end
    end

    assign w_rx_s    = r_sync[SYNC_STAGES-1];
    assign w_bit_end = (r_bit_cnt == FullM1);

    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_bit_idx_d = r_bit_idx;
        w_shreg_d   = r_shreg;
        w_push_req  = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_d  = r_par_bit;
        w_parity_err = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_bit_cnt_d = '0;
                    w_state_d   = StStart;
                end
            end
            StStart: begin
                w_bit_cnt_d = r_bit_cnt + 1'b1;
                if (r_bit_cnt == HalfM1) begin
                    if (!w_rx_s) begin
                        w_bit_cnt_d = '0;
                        w_bit_idx_d = '0;
                        w_state_d   = StData;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StData: begin
                w_bit_cnt_d = r_bit_cnt + 1'b1;
                if (w_bit_end) begin
                    w_shreg_d   = {w_rx_s, r_shreg[7:1]};
                    w_bit_cnt_d = '0;
                    w_bit_idx_d = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                w_bit_cnt_d = r_bit_cnt + 1'b1;
                if (w_bit_end) begin
                    w_par_bit_d = w_rx_s;
                    w_bit_cnt_d = '0;
                    w_state_d   = StStop;
                end
            end
`endif
            StStop: begin
                w_bit_cnt_d = r_bit_cnt + 1'b1;
                if (w_bit_end) begin
                    w_bit_cnt_d = '0;
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        // Even parity: data plus parity bit must hold an even number of ones.
                        w_push_req   = ~^{r_shreg, r_par_bit};
                        w_parity_err = ^{r_shreg, r_par_bit};
`else
                        w_push_req   = 1'b1;
`endif
                        w_state_d = StIdle;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                if (w_rx_s) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_bit_idx <= w_bit_idx_d;
            r_shreg   <= w_shreg_d;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= w_par_bit_d;
`endif
        end
    end

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_full = (r_count == DepthCnt);
    assign w_pop  = o_rd_valid && i_rd_ready;
    assign w_push = w_push_req && (!w_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shreg;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rd_valid   = (r_count != '0);
    assign o_rd_data    = r_mem[r_rd_ptr];
    assign o_fifo_count = r_count;
    assign o_busy       = (r_state != StIdle);
    assign o_frame_err  = w_frame_err;
    assign o_overrun    = w_push_req && w_full && !w_pop;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = w_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed and random frames against a queue-based model.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LATENCY = SYNC + CPB / 2 + (9 + PAR) * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [2:0] fifo_count;
    logic       busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_in      (rx_in),
        .i_rd_ready   (rd_ready),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_fifo_count (fifo_count),
        .o_busy       (busy),
        .o_frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (parity_err),
`endif
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned t_rise = 0;
    int          n_fe = 0, n_ovr = 0, n_pe = 0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and rd_valid rise time, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err) n_fe <= n_fe + 1;
        if (overrun) n_ovr <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_pe <= n_pe + 1;
`endif
        if (rd_valid && !prev_valid) t_rise <= cyc;
        prev_valid <= rd_valid;
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_fe = 0, exp_ovr = 0, exp_pe = 0;
    int unsigned t_start = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serialise one frame; the model decides what the receiver should do with it.
    task automatic send(input logic [7:0] d, input bit stop, input int hold,
                        input bit pulse_rdy, input bit par_bad);
        bit good_par;
        good_par = (PAR == 0) || !par_bad;
        rx_in   = 1'b0;
        t_start = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            tick(CPB);
        end
        if (PAR != 0) begin
            rx_in = (^d) ^ par_bad;
            tick(CPB);
        end
        rx_in = stop;
        for (int j = 0; j < CPB; j++) begin
            if (pulse_rdy) begin
                rd_ready = (j == SYNC + CPB / 2);
                if (j == SYNC + CPB / 2 && exp_q.size() > 0) begin
                    check("pop_at_push_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
                end
            end
            tick(1);
        end
        rd_ready = 1'b0;
        if (!stop) begin
            tick(hold);
            check("break_busy", {31'd0, busy}, 32'd1);
            exp_fe++;
        end else if (!good_par) begin
            exp_pe++;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
        end else begin
            exp_ovr++;
        end
        rx_in = 1'b1;
        tick(4);
    endtask

    task automatic drain(input string tag);
        int n_exp;
        int n_got;
        n_exp    = exp_q.size();
        n_got    = 0;
        rd_ready = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (rd_valid) begin
                if (exp_q.size() > 0) begin
                    check(tag, {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
                end
                n_got++;
                tick(1);
            end
        end
        rd_ready = 1'b0;
        check({tag, "_count"}, n_got, n_exp);
        check({tag, "_empty"}, {31'd0, rd_valid}, 32'd0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_fe"}, n_fe, exp_fe);
        check({tag, "_ovr"}, n_ovr, exp_ovr);
        check({tag, "_pe"}, n_pe, exp_pe);
        check({tag, "_cnt"}, {29'd0, fifo_count}, exp_q.size());
    endtask

    logic [7:0] b;
    bit         st;

    initial begin
        tick(3);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data", {24'd0, rd_data}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single byte, latency from start edge to rd_valid
        send(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        check("t1_valid", {31'd0, rd_valid}, 32'd1);
        check("t1_data", {24'd0, rd_data}, 32'hA5);
        check("t1_latency", t_rise - t_start, LATENCY);
        check_flags("t1");
        drain("t1_drain");

        // Fill past capacity
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 0, 1'b0, 1'b0);
        send(8'h55, 1'b1, 0, 1'b0, 1'b0);
        check_flags("t2");
        drain("t2_drain");

        // Start-bit glitch
        rx_in = 1'b0;
        tick(5);
        rx_in = 1'b1;
        check("t3_busy_hi", {31'd0, busy}, 32'd1);
        tick(9);
        check("t3_busy_lo", {31'd0, busy}, 32'd0);
        check_flags("t3");

        // Framing error with a held break, then a clean byte
        send(8'h3C, 1'b0, 40 - CPB, 1'b0, 1'b0);
        check("t4_busy_after", {31'd0, busy}, 32'd0);
        check_flags("t4a");
        send(8'h7E, 1'b1, 0, 1'b0, 1'b0);
        check("t4_data", {24'd0, rd_data}, 32'h7E);
        check_flags("t4b");
        drain("t4_drain");

        // Full FIFO with a pop coinciding with the push
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b1, 0, 1'b0, 1'b0);
        send(8'h99, 1'b1, 0, 1'b1, 1'b0);
        check_flags("t5");
        drain("t5_drain");

        // Random frames, some with bad stop bits
        for (int n = 0; n < 8; n++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            send(b, st, $urandom_range(0, 8), 1'b0, 1'b0);
            check_flags("t6");
        end
        drain("t6_drain");

        if (PAR != 0) begin
            send(8'h07, 1'b1, 0, 1'b0, 1'b1);
            check_flags("t7_bad");
            send(8'h07, 1'b1, 0, 1'b0, 1'b0);
            check("t7_data", {24'd0, rd_data}, 32'h07);
            check_flags("t7_good");
            drain("t7_drain");
        end

        // Reset in the middle of a frame discards FIFO and partial byte
        send(8'h5A, 1'b1, 0, 1'b0, 1'b0);
        rx_in = 1'b0;
        tick(40);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t8_count", {29'd0, fifo_count}, 32'd0);
        check("t8_valid", {31'd0, rd_valid}, 32'd0);
        check("t8_busy", {31'd0, busy}, 32'd0);
        check("t8_data", {24'd0, rd_data}, 32'd0);
        rx_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send(8'hC3, 1'b1, 0, 1'b0, 1'b0);
        check_flags("t8");
        drain("t8_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
